// File: rtl/aoi21_vector_sequencer_pkg.sv
// Shared definitions for the standard-cell vector sequencer: state encoding,
// golden truth tables per library cell and the vector bit-order convention.
package aoi21_vector_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Vector bit order for 3-input cells: {B, A1, A0}, bit0 = A0.
    localparam int unsigned VEC_A0 = 0;
    localparam int unsigned VEC_A1 = 1;
    localparam int unsigned VEC_B  = 2;

    localparam int unsigned AOI21_NIN = 3;
    localparam int unsigned SETTLE_W  = 8;

    // Golden outputs, bit i = expected Y for vector index i.
    localparam logic [7:0] AOI21_TT = 8'h07;  // ~((A0 & A1) | B)
    localparam logic [7:0] OAI21_TT = 8'h1F;  // ~((A0 | A1) & B)
    localparam logic [3:0] NAND2_TT = 4'h7;   // ~(A0 & A1)

endpackage

// File: rtl/aoi21_vector_sequencer_cmp.sv
// Golden lookup, saturating mismatch counter and first-fail capture;
// independent of the sequencing so wider cells reuse it unchanged.
module aoi21_vector_sequencer_cmp #(
    parameter int unsigned          NIN   = 3,
    parameter logic [(2**NIN)-1:0]  TRUTH = 8'h07,
    parameter int unsigned          CNTW  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            sample,
    input  logic [NIN-1:0]  vec,
    input  logic            y,
    output logic            mismatch_c,
    output logic [CNTW-1:0] errcnt,
    output logic [NIN-1:0]  fail_vec,
    output logic            fail_vld
);

    assign mismatch_c = y ^ TRUTH[vec];

    // Count saturates at all-ones; only the first failing vector is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errcnt   <= '0;
            fail_vec <= '0;
            fail_vld <= 1'b0;
        end else if (clear) begin
            errcnt   <= '0;
            fail_vld <= 1'b0;
        end else if (sample && mismatch_c) begin
            if (errcnt != '1) begin
                errcnt <= errcnt + CNTW'(1);
            end
            if (!fail_vld) begin
                fail_vec <= vec;
                fail_vld <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/aoi21_vector_sequencer.sv
// Built-in self-check sequencer: walks a combinational cell through all input
// vectors, samples its output after a settle time and reports pass/fail.
module aoi21_vector_sequencer
    import aoi21_vector_sequencer_pkg::*;
#(
    parameter int unsigned          NIN    = AOI21_NIN,
    parameter logic [(2**NIN)-1:0]  TRUTH  = AOI21_TT,
    parameter int unsigned          SETTLE = 2,
    parameter int unsigned          CNTW   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            y,
    output logic [NIN-1:0]  vec,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [CNTW-1:0] errcnt,
    output logic [NIN-1:0]  fail_vec,
    output logic            fail_vld
);

    localparam logic [SETTLE_W-1:0] SETTLE_C = SETTLE_W'(SETTLE);

    state_t                state, state_n;
    logic [NIN-1:0]        vec_n;
    logic [SETTLE_W-1:0]   cnt, cnt_n;
    logic                  busy_n, done_n, pass_n;
    logic                  clear_c, sample_c, mismatch_c;

    aoi21_vector_sequencer_cmp #(
        .NIN   (NIN),
        .TRUTH (TRUTH),
        .CNTW  (CNTW)
    ) u_cmp (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear_c),
        .sample     (sample_c),
        .vec        (vec),
        .y          (y),
        .mismatch_c (mismatch_c),
        .errcnt     (errcnt),
        .fail_vec   (fail_vec),
        .fail_vld   (fail_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            vec   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            state <= state_n;
            vec   <= vec_n;
            cnt   <= cnt_n;
            busy  <= busy_n;
            done  <= done_n;
            pass  <= pass_n;
        end
    end

    // Next state and next registered outputs; abort overrides everything.
    always_comb begin
        state_n  = state;
        vec_n    = vec;
        cnt_n    = cnt;
        done_n   = 1'b0;
        pass_n   = pass;
        clear_c  = 1'b0;
        sample_c = 1'b0;
        if (abort) begin
            state_n = ST_IDLE;
            vec_n   = '0;
            cnt_n   = '0;
            pass_n  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_n = ST_RUN;
                        vec_n   = '0;
                        cnt_n   = '0;
                        pass_n  = 1'b0;
                        clear_c = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cnt != SETTLE_C) begin
                        cnt_n = cnt + SETTLE_W'(1);
                    end else begin
                        sample_c = 1'b1;
                        cnt_n    = '0;
                        if (vec == '1) begin
                            // Final compare folds into PASS so it is valid with DONE.
                            state_n = ST_FIN;
                            vec_n   = '0;
                            done_n  = 1'b1;
                            pass_n  = (errcnt == '0) && !mismatch_c;
                        end else begin
                            vec_n = vec + NIN'(1);
                        end
                    end
                end
                ST_FIN: begin
                    state_n = ST_IDLE;
                end
                default: begin
                    state_n = ST_IDLE;
                    vec_n   = '0;
                    cnt_n   = '0;
                end
            endcase
        end
        busy_n = (state_n == ST_RUN);
    end

endmodule

// File: tb/tb_aoi21_vector_sequencer.sv
// Directed bench for aoi21_vector_sequencer: table-driven full runs against a
// behavioural aoi21 with injectable faults, plus abort/reset/parameter corners.
module tb_aoi21_vector_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, y;
    logic [2:0] vec;
    logic       busy, done, pass, fail_vld;
    logic [7:0] errcnt;
    logic [2:0] fail_vec;

    logic       start0, y0;
    logic [2:0] vec0;
    logic       busy0, done0, pass0, fail_vld0;
    logic [7:0] errcnt0;
    logic [2:0] fail_vec0;

    logic       start2, y2;
    logic [2:0] vec2;
    logic       busy2, done2, pass2, fail_vld2;
    logic [1:0] errcnt2;
    logic [2:0] fail_vec2;

    int mode;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aoi21_vector_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .y(y),
        .vec(vec), .busy(busy), .done(done), .pass(pass), .errcnt(errcnt),
        .fail_vec(fail_vec), .fail_vld(fail_vld)
    );

    aoi21_vector_sequencer #(.SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .y(y0),
        .vec(vec0), .busy(busy0), .done(done0), .pass(pass0), .errcnt(errcnt0),
        .fail_vec(fail_vec0), .fail_vld(fail_vld0)
    );

    aoi21_vector_sequencer #(.CNTW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort), .y(y2),
        .vec(vec2), .busy(busy2), .done(done2), .pass(pass2), .errcnt(errcnt2),
        .fail_vec(fail_vec2), .fail_vld(fail_vld2)
    );

    // Cell model: 0 good, 1 stuck-at-0, 2 stuck-at-1, 3 inverted,
    // 4 wrong only at vector 6, 5 stuck-at-0 except vector 0.
    function automatic logic aoi(input logic [2:0] v);
        return ~((v[0] & v[1]) | v[2]);
    endfunction

    always_comb begin
        case (mode)
            1:       y = 1'b0;
            2:       y = 1'b1;
            3:       y = ~aoi(vec);
            4:       y = (vec == 3'd6) ? ~aoi(vec) : aoi(vec);
            5:       y = (vec == 3'd0) ? aoi(vec) : 1'b0;
            default: y = aoi(vec);
        endcase
    end
    assign y0 = aoi(vec0);
    assign y2 = 1'b1;

    typedef struct {
        int mode;
        int err;
        int fvld;
        int fvec;
        int pass;
        bit poke;
    } run_t;

    run_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full run on the main instance; optionally pokes START while busy.
    task automatic do_run(input run_t r);
        int done_at;
        mode  = r.mode;
        start = 1'b1;
        step();
        start   = 1'b0;
        done_at = -1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                done_at = i;
                break;
            end
            if (i < 24) begin
                chk("vec_step", int'(vec), i / 3);
                chk("busy_run", int'(busy), 1);
            end
            start = r.poke && (i % 5 == 2) && (i < 20);
            step();
        end
        start = 1'b0;
        chk("done_time", done_at, 24);
        chk("pass_at_done", int'(pass), r.pass);
        step();
        chk("done_one_cycle", int'(done), 0);
        chk("busy_after", int'(busy), 0);
        chk("vec_after", int'(vec), 0);
        chk("errcnt", int'(errcnt), r.err);
        chk("fail_vld", int'(fail_vld), r.fvld);
        if (r.fvld != 0) chk("fail_vec", int'(fail_vec), r.fvec);
        chk("pass", int'(pass), r.pass);
        step();
        chk("no_retrigger", int'(busy), 0);
    endtask

    initial begin
        int done_at;
        int done_cnt;

        tbl[0] = '{mode: 0, err: 0, fvld: 0, fvec: 0, pass: 1, poke: 1'b0};
        tbl[1] = '{mode: 1, err: 3, fvld: 1, fvec: 0, pass: 0, poke: 1'b0};
        tbl[2] = '{mode: 2, err: 5, fvld: 1, fvec: 3, pass: 0, poke: 1'b0};
        tbl[3] = '{mode: 4, err: 1, fvld: 1, fvec: 6, pass: 0, poke: 1'b0};
        tbl[4] = '{mode: 3, err: 8, fvld: 1, fvec: 0, pass: 0, poke: 1'b0};
        tbl[5] = '{mode: 0, err: 0, fvld: 0, fvec: 0, pass: 1, poke: 1'b1};

        mode   = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        start0 = 1'b0;
        start2 = 1'b0;
        step();
        step();
        chk("rst_vec", int'(vec), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_errcnt", int'(errcnt), 0);
        chk("rst_fail_vec", int'(fail_vec), 0);
        chk("rst_fail_vld", int'(fail_vld), 0);
        rst_n = 1'b1;
        step();
        chk("idle_wait", int'(busy), 0);

        for (int t = 0; t < 6; t++) begin
            do_run(tbl[t]);
        end

        // Abort while vector 4 is applied; vector 3 already failed under stuck-at-1.
        mode  = 2;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (12) step();
        chk("abort_pre_vec", int'(vec), 4);
        chk("abort_pre_err", int'(errcnt), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_vec", int'(vec), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_pass", int'(pass), 0);
        chk("abort_err_held", int'(errcnt), 1);
        chk("abort_fvld_held", int'(fail_vld), 1);
        chk("abort_fvec_held", int'(fail_vec), 3);
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) done_cnt++;
            step();
        end
        chk("abort_no_done", done_cnt, 0);
        do_run(tbl[0]);

        // START held high re-triggers on the first IDLE cycle after FIN.
        mode  = 0;
        start = 1'b1;
        step();
        done_at = -1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                done_at = i;
                break;
            end
            step();
        end
        chk("held_done_time", done_at, 24);
        step();
        chk("held_idle_gap", int'(busy), 0);
        step();
        chk("held_retrig_busy", int'(busy), 1);
        chk("held_retrig_vec", int'(vec), 0);
        start = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("held_abort_busy", int'(busy), 0);

        // SETTLE=0: one cycle per vector, DONE after E0+8.
        start0 = 1'b1;
        step();
        start0  = 1'b0;
        done_at = -1;
        for (int i = 0; i < 20; i++) begin
            if (done0) begin
                done_at = i;
                break;
            end
            if (i < 8) chk("s0_vec", int'(vec0), i);
            step();
        end
        chk("s0_done_time", done_at, 8);
        chk("s0_pass", int'(pass0), 1);
        chk("s0_errcnt", int'(errcnt0), 0);

        // CNTW=2 with stuck-at-1: five mismatches saturate at 3.
        start2 = 1'b1;
        step();
        start2  = 1'b0;
        done_at = -1;
        for (int i = 0; i < 40; i++) begin
            if (done2) begin
                done_at = i;
                break;
            end
            step();
        end
        chk("c2_done_time", done_at, 24);
        chk("c2_errcnt_sat", int'(errcnt2), 3);
        chk("c2_fail_vec", int'(fail_vec2), 3);
        chk("c2_pass", int'(pass2), 0);

        // Reset mid-run at E0+10 clears everything without waiting for a clock.
        mode  = 5;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        chk("mrst_pre_err", int'(errcnt), 2);
        chk("mrst_pre_fvec", int'(fail_vec), 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_vec", int'(vec), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_pass", int'(pass), 0);
        chk("mrst_errcnt", int'(errcnt), 0);
        chk("mrst_fail_vec", int'(fail_vec), 0);
        chk("mrst_fail_vld", int'(fail_vld), 0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("mrst_idle_busy", int'(busy), 0);
        chk("mrst_idle_vec", int'(vec), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
